dcache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that services the pipeline's data-memory requests on the datapath_cache interface. Sits between the datapath's memory stage and the memory controller. Answers hits in the request cycle, fills and evicts on misses, and on halt flushes all dirty frames, writes the hit count and signals completion.

---
 rtl/dcache_if.sv | 33 +++
 rtl/dcache.sv | 162 ++++++++++++++++
 tb/tb_dcache.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// dcache_if: datapath_cache bundle plus the cache <-> memory-controller bus.
//   slave  : cache view. Takes datapath requests and halt, returns dhit, dmemload
//            and flushed. Drives dREN, dWEN, daddr and dstore to memory and takes
//            dload and dwait back.
//   master : environment view (datapath + memory controller), the mirror image.
interface dcache_if;
  // datapath side
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  // memory side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache with one-word frames.
// Hits are answered combinationally in the request cycle. A miss evicts a dirty
// victim (WB) and then fills (FETCH). On halt, every dirty frame is written back,
// the hit count is stored at HITADDR, and flushed is raised and held until reset.
// Ports:
//   CLK  : clock
//   nRST : asynchronous, active-low reset
//   bus  : dcache_if.slave (datapath request/response and memory bus)
module dcache #(
  parameter int          FRAMES  = 16,
  parameter logic [31:0] HITADDR = 32'h0000_3100
) (
  input logic      CLK,
  input logic      nRST,
  dcache_if.slave  bus
);
  localparam int IW = $clog2(FRAMES);
  localparam int TW = 32 - IW - 2;

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, CNT, DONE} state_e;

  typedef struct packed {
    logic          valid;
    logic          dirty;
    logic [TW-1:0] tag;
    logic [31:0]   data;
  } frame_t;

  state_e        state_q, state_d;
  logic [IW-1:0] fidx_q, fidx_d;
  logic [31:0]   hitcnt_q, hitcnt_d;
  logic          miss_q, miss_d;
  frame_t        frame_q [FRAMES];

  // frame update strobes, decoded by the FSM and applied in the frame register
  logic wr_hit, wb_done, fill_done, fl_clean;

  logic          req;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  frame_t        cur, fl;
  logic          tag_hit, halt_go;
  logic          unused_addr_bits;

  assign req     = bus.dmemREN | bus.dmemWEN;
  assign idx     = bus.dmemaddr[IW+1:2];
  assign tag     = bus.dmemaddr[31:IW+2];
  assign cur     = frame_q[idx];
  assign fl      = frame_q[fidx_q];
  assign tag_hit = cur.valid && (cur.tag == tag);
  // The hit that completes a miss goes ahead of halt. Otherwise halt wins over
  // any request in the same cycle.
  assign halt_go = bus.halt && !miss_q;
  assign unused_addr_bits = ^bus.dmemaddr[1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      fidx_q   <= '0;
      hitcnt_q <= '0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fidx_q   <= fidx_d;
      hitcnt_q <= hitcnt_d;
      miss_q   <= miss_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fidx_d       = fidx_q;
    hitcnt_d     = hitcnt_q;
    miss_d       = miss_q;
    wr_hit       = 1'b0;
    wb_done      = 1'b0;
    fill_done    = 1'b0;
    fl_clean     = 1'b0;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.flushed  = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    unique case (state_q)
      IDLE: begin
        if (halt_go) begin
          state_d = FLUSH;
          fidx_d  = '0;
        end else if (req) begin
          if (tag_hit) begin
            bus.dhit     = 1'b1;
            bus.dmemload = cur.data;
            wr_hit       = bus.dmemWEN;   // a write takes priority over a read
            miss_d       = 1'b0;
            // the hit that closes a miss is not counted
            if (!miss_q) hitcnt_d = hitcnt_q + 32'd1;
          end else begin
            miss_d  = 1'b1;
            state_d = (cur.valid && cur.dirty) ? WB : FETCH;
          end
        end
      end
      WB: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {cur.tag, idx, 2'b00};
        bus.dstore = cur.data;
        if (!bus.dwait) begin
          wb_done = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        bus.dREN  = 1'b1;
        bus.daddr = {bus.dmemaddr[31:2], 2'b00};
        if (!bus.dwait) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      FLUSH: begin
        if (fl.valid && fl.dirty) begin
          bus.dWEN   = 1'b1;
          bus.daddr  = {fl.tag, fidx_q, 2'b00};
          bus.dstore = fl.data;
          fl_clean   = !bus.dwait;
        end
        // a clean or invalid frame advances at once; a dirty one advances
        // when its write is accepted
        if (!(fl.valid && fl.dirty) || !bus.dwait) begin
          if (fidx_q == IW'(FRAMES - 1)) state_d = CNT;
          else                           fidx_d  = fidx_q + IW'(1);
        end
      end
      CNT: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = HITADDR;
        bus.dstore = hitcnt_q;
        if (!bus.dwait) state_d = DONE;
      end
      DONE: begin
        bus.flushed = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FRAMES; i++) frame_q[i] <= '0;
    end else begin
      if (wr_hit) begin
        frame_q[idx].data  <= bus.dmemstore;
        frame_q[idx].dirty <= 1'b1;
      end
      if (wb_done)   frame_q[idx].dirty <= 1'b0;
      if (fill_done) frame_q[idx] <= '{valid: 1'b1, dirty: 1'b0, tag: tag, data: bus.dload};
      if (fl_clean)  frame_q[fidx_q].dirty <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: scenario tasks for dcache. A memory responder inserts lat dwait
// cycles. Every expected bus transfer goes into exp_q when its stimulus is set
// up, and the monitor pops and checks each transfer as it completes.
module tb_dcache;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  dcache_if bus();

  dcache #(.FRAMES(16), .HITADDR(32'h0000_3100)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
  } xact_t;

  xact_t       exp_q[$];
  int          checks = 0;
  int          fails  = 0;
  int          lat    = 0;
  int          wcnt;
  int          exp_hits = 0;
  logic [31:0] mem [0:4095];

  // memory responder
  always @(posedge CLK or negedge nRST)
    if (!nRST) wcnt <= 0;
    else if ((bus.dREN || bus.dWEN) && bus.dwait) wcnt <= wcnt + 1;
    else wcnt <= 0;
  assign bus.dwait = (bus.dREN || bus.dWEN) && (wcnt < lat);
  assign bus.dload = mem[bus.daddr[13:2]];

  // bus monitor / scoreboard
  always @(negedge CLK) begin
    if (nRST) begin
      checks++;
      if (bus.dREN && bus.dWEN) begin
        fails++;
        $display("FAIL overlap: dREN=%b dWEN=%b both high at %0t", bus.dREN, bus.dWEN, $time);
      end
      if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_xfer: wr=%b addr=%h data=%h, none expected", bus.dWEN, bus.daddr, bus.dstore);
        end else begin
          xact_t x;
          x = exp_q.pop_front();
          if (x.wr !== bus.dWEN || x.a !== bus.daddr || (x.wr && x.d !== bus.dstore)) begin
            fails++;
            $display("FAIL xfer: got wr=%b addr=%h data=%h, expected wr=%b addr=%h data=%h",
                     bus.dWEN, bus.daddr, bus.dstore, x.wr, x.a, x.d);
          end
        end
      end
    end
  end

  function automatic void push(input bit wr, input logic [31:0] a, input logic [31:0] d);
    xact_t x;
    x.wr = wr; x.a = a; x.d = d;
    exp_q.push_back(x);
  endfunction

  // One request held until dhit. Checks latency in cycles and read data, then
  // drops the request and checks that the outputs return to idle.
  task automatic access(input bit ren, input bit wen, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input bit chk, input int ecyc, input string nm);
    int cyc;
    bit got;
    @(posedge CLK); #1;
    bus.dmemREN = ren; bus.dmemWEN = wen; bus.dmemaddr = a; bus.dmemstore = d;
    cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge CLK);
      if (bus.dhit === 1'b1) got = 1; else cyc++;
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL %s_timeout: no dhit after %0d cycles", nm, cyc);
    end else begin
      checks++;
      if (cyc != ecyc) begin
        fails++;
        $display("FAIL %s_latency: got %0d cycles, expected %0d", nm, cyc, ecyc);
      end
      if (chk) begin
        checks++;
        if (bus.dmemload !== exp) begin
          fails++;
          $display("FAIL %s_load: got %h, expected %h", nm, bus.dmemload, exp);
        end
      end
    end
    @(posedge CLK); #1;
    bus.dmemREN = 0; bus.dmemWEN = 0;
    @(negedge CLK);
    checks++;
    if (bus.dhit !== 1'b0 || bus.dmemload !== 32'h0) begin
      fails++;
      $display("FAIL %s_idle: dhit=%b dmemload=%h, expected 0/0", nm, bus.dhit, bus.dmemload);
    end
  endtask

  task automatic test_reset();
    nRST = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({bus.dhit, bus.dREN, bus.dWEN, bus.flushed} !== 4'b0 || bus.daddr !== 32'h0 ||
        bus.dstore !== 32'h0 || bus.dmemload !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: dhit=%b dREN=%b dWEN=%b flushed=%b daddr=%h dstore=%h dmemload=%h, expected all 0",
               bus.dhit, bus.dREN, bus.dWEN, bus.flushed, bus.daddr, bus.dstore, bus.dmemload);
    end
    nRST = 1;
  endtask

  task automatic test_cold_read();
    lat = 2;
    push(0, 32'h40, 32'h0);
    access(1, 0, 32'h40, 0, 32'hDEADBEEF, 1, 4, "cold_read");
    access(1, 0, 32'h40, 0, 32'hDEADBEEF, 1, 0, "reread");
    exp_hits++;
  endtask

  task automatic test_write_alloc();
    lat = 0;
    push(0, 32'h80, 32'h0);            // victim 0x40 is clean: fill only
    access(0, 1, 32'h80, 32'h1234, 0, 0, 2, "write_miss");
    access(1, 0, 32'h80, 0, 32'h1234, 1, 0, "write_readback");
    exp_hits++;
  endtask

  task automatic test_dirty_evict();
    lat = 1;
    push(1, 32'h80, 32'h1234);
    push(0, 32'h480, 32'h0);
    access(1, 0, 32'h480, 0, 32'hCAFE0480, 1, 5, "dirty_evict");
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL evict_xfers: %0d transfers outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_rw_both();
    lat = 0;
    access(1, 1, 32'h480, 32'h55AA, 0, 0, 0, "rw_both");
    exp_hits++;
    access(1, 0, 32'h480, 0, 32'h55AA, 1, 0, "rw_both_read");
    exp_hits++;
  endtask

  task automatic test_back_to_back();
    lat = 0;
    push(0, 32'h08, 0);
    push(0, 32'h14, 0);
    access(0, 1, 32'h08, 32'hA0A0_0008, 0, 0, 2, "b2b_w2");
    access(0, 1, 32'h14, 32'hB0B0_0014, 0, 0, 2, "b2b_w5");
    access(1, 0, 32'h08, 0, 32'hA0A0_0008, 1, 0, "b2b_r2");
    exp_hits++;
    access(1, 0, 32'h14, 0, 32'hB0B0_0014, 1, 0, "b2b_r5");
    exp_hits++;
  endtask

  task automatic test_flush();
    bit saw_hit, done;
    lat = 1;
    push(1, 32'h480, 32'h55AA);
    push(1, 32'h08, 32'hA0A0_0008);
    push(1, 32'h14, 32'hB0B0_0014);
    push(1, 32'h3100, exp_hits);
    @(posedge CLK); #1;
    bus.halt = 1; bus.dmemREN = 1; bus.dmemaddr = 32'h08;   // halt beats this hit
    saw_hit = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (bus.dhit) saw_hit = 1;
      if (bus.flushed) done = 1;
    end
    checks++;
    if (!done) begin fails++; $display("FAIL flush_timeout: flushed=%b, expected 1", bus.flushed); end
    checks++;
    if (saw_hit) begin fails++; $display("FAIL halt_priority: dhit=1 during flush, expected 0"); end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL flush_xfers: %0d transfers outstanding, expected 0", exp_q.size());
    end
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (bus.flushed !== 1'b1 || bus.dhit !== 1'b0 || bus.dREN !== 1'b0 || bus.dWEN !== 1'b0) begin
        fails++;
        $display("FAIL done_hold: flushed=%b dhit=%b dREN=%b dWEN=%b, expected 1/0/0/0",
                 bus.flushed, bus.dhit, bus.dREN, bus.dWEN);
      end
    end
    bus.dmemREN = 0;
  endtask

  task automatic test_reset_mid_fetch();
    bit seen;
    bus.halt = 0;
    nRST = 0;
    @(negedge CLK);
    nRST = 1;
    lat = 5;
    push(0, 32'h40, 0);
    @(posedge CLK); #1;
    bus.dmemREN = 1; bus.dmemaddr = 32'h40;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (bus.dREN) seen = 1;
    end
    checks++;
    if (!seen) begin fails++; $display("FAIL fetch_start: dREN=%b, expected 1", bus.dREN); end
    #2 nRST = 0;
    #1;
    checks++;
    if ({bus.dhit, bus.dREN, bus.dWEN, bus.flushed} !== 4'b0 || bus.daddr !== 32'h0 ||
        bus.dstore !== 32'h0 || bus.dmemload !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: dhit=%b dREN=%b dWEN=%b flushed=%b daddr=%h, expected all 0",
               bus.dhit, bus.dREN, bus.dWEN, bus.flushed, bus.daddr);
    end
    exp_q.delete();                  // the aborted fill never completes
    bus.dmemREN = 0;
    @(negedge CLK);
    nRST = 1;
    lat = 0;
    push(0, 32'h40, 0);
    access(1, 0, 32'h40, 0, 32'hDEADBEEF, 1, 2, "post_reset_miss");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dmemREN = 0; bus.dmemWEN = 0; bus.dmemaddr = 0; bus.dmemstore = 0; bus.halt = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[32'h40 >> 2]  = 32'hDEADBEEF;
    mem[32'h480 >> 2] = 32'hCAFE0480;
    test_reset();
    test_cold_read();
    test_write_alloc();
    test_dirty_evict();
    test_rw_both();
    test_back_to_back();
    test_flush();
    test_reset_mid_fetch();
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
